// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR
   } state_t;

   localparam logic [7:0] START_BYTE = 8'hA5;
   localparam int         MAX_INSTR  = 32;

   // Instruction count is legal when it is 1..MAX_INSTR.
   function automatic logic len_ok(input logic [7:0] n);
      return (n != 8'd0) && (n <= 8'(MAX_INSTR));
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-source and program-memory write port bundle for the loader.
// Latency: n/a (wiring only).
// Backpressure: rx_ready from the loader gates byte acceptance.
interface program_loader_if #(
   parameter int ADDR_W  = 5,
   parameter int INSTR_W = 16
);
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic               pm_we;
   logic [ADDR_W-1:0]  pm_addr;
   logic [INSTR_W-1:0] pm_wdata;

   // Host/memory environment side
   modport master (
      output rx_data, rx_valid,
      input  rx_ready, pm_we, pm_addr, pm_wdata
   );

   // Loader side
   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, pm_we, pm_addr, pm_wdata
   );
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte idle counter with a terminal flag at TIMEOUT.
// Latency: hit_o is registered-count compare, asserts TIMEOUT enabled cycles after clear.
// Backpressure: none; counter saturates at TIMEOUT.
module loader_timeout #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   assign hit_o = (cnt_q == CW'(TIMEOUT));

   // Clear on every accepted byte, otherwise count up while enabled until terminal.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !hit_o) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/program_loader.sv
// Frames, checksums and writes a byte-stream program image; holds the core until verified.
// Latency: pm_we one cycle after LO byte; done/error one cycle after CSUM/LEN byte.
// Backpressure: rx_ready drops only for the single WRITE cycle of each instruction.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int INSTR_W = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   program_loader_if.slave  bus,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);
   state_t             state_q;
   logic [5:0]         n_q;
   logic [ADDR_W-1:0]  idx_q;
   logic [7:0]         sum_q;
   logic [7:0]         hi_q;
   logic               pm_we_q;
   logic [ADDR_W-1:0]  pm_addr_q;
   logic [INSTR_W-1:0] pm_wdata_q;
   logic               cpu_hold_q, done_q, error_q;

   logic       acc;
   logic       in_frame;
   logic       tmo_hit;
   logic       last;
   logic [7:0] sum_d;

   assign bus.rx_ready = (state_q != WRITE);
   assign acc          = bus.rx_valid && bus.rx_ready;
   assign in_frame     = (state_q == LEN) || (state_q == HI) ||
                         (state_q == LO)  || (state_q == CSUM);
   assign sum_d        = sum_q + bus.rx_data;
   assign last         = (6'(idx_q) == (n_q - 6'd1));

   assign bus.pm_we    = pm_we_q;
   assign bus.pm_addr  = pm_addr_q;
   assign bus.pm_wdata = pm_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;

   loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clr_i (acc),
      .en_i  (in_frame),
      .hit_o (tmo_hit)
   );

   // Loader FSM with registered memory-write and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         idx_q      <= '0;
         sum_q      <= '0;
         hi_q       <= '0;
         pm_we_q    <= 1'b0;
         pm_addr_q  <= '0;
         pm_wdata_q <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         pm_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (acc && bus.rx_data == START_BYTE) state_q <= LEN;
            end
            LEN: begin
               if (acc) begin
                  if (len_ok(bus.rx_data)) begin
                     n_q     <= bus.rx_data[5:0];
                     idx_q   <= '0;
                     sum_q   <= '0;
                     state_q <= HI;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  state_q <= ERR;
                  error_q <= 1'b1;
               end
            end
            HI: begin
               if (acc) begin
                  hi_q    <= bus.rx_data;
                  sum_q   <= sum_d;
                  state_q <= LO;
               end else if (tmo_hit) begin
                  state_q <= ERR;
                  error_q <= 1'b1;
               end
            end
            LO: begin
               if (acc) begin
                  sum_q      <= sum_d;
                  pm_we_q    <= 1'b1;
                  pm_addr_q  <= idx_q;
                  pm_wdata_q <= INSTR_W'({hi_q, bus.rx_data});
                  state_q    <= WRITE;
               end else if (tmo_hit) begin
                  state_q <= ERR;
                  error_q <= 1'b1;
               end
            end
            WRITE: begin
               // Index is bounded by N-1, so it never needs to wrap.
               if (last) begin
                  state_q <= CSUM;
               end else begin
                  idx_q   <= idx_q + ADDR_W'(1);
                  state_q <= HI;
               end
            end
            CSUM: begin
               if (acc) begin
                  if (bus.rx_data == sum_q) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  state_q <= ERR;
                  error_q <= 1'b1;
               end
            end
            DONE, ERR: begin
               // Only a start byte restarts; the core is held again from the next cycle.
               if (acc && bus.rx_data == START_BYTE) begin
                  state_q    <= LEN;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  cpu_hold_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed frames with hand-computed writes/checksums.
// Latency: expectations are queued by stimulus, consumed by a negedge monitor.
// Backpressure: byte sender waits on rx_ready with a bounded retry count.
module tb_program_loader;
   localparam int TMO = 1000;
   localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

   typedef struct {
      int          kind;
      logic [4:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cpu_hold, done, error;

   int n_chk = 0;
   int n_fail = 0;
   exp_t q[$];

   program_loader_if #(.ADDR_W(5), .INSTR_W(16)) bus ();

   program_loader #(.ADDR_W(5), .INSTR_W(16), .TIMEOUT(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop expectations on write strobes and status rising edges.
   logic done_p = 1'b0, err_p = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         done_p = 1'b0;
         err_p  = 1'b0;
      end else begin
         if (bus.pm_we) begin
            if (q.size() == 0) chk("unexpected_write", 32'(bus.pm_addr), 32'hFFFF_FFFF);
            else begin
               e = q.pop_front();
               chk("wr_kind", 32'(K_WR), 32'(e.kind));
               chk("wr_addr", 32'(bus.pm_addr), 32'(e.addr));
               chk("wr_data", 32'(bus.pm_wdata), 32'(e.data));
            end
         end
         if (done && !done_p) begin
            if (q.size() == 0) chk("unexpected_done", 32'(done), 32'(0));
            else begin
               e = q.pop_front();
               chk("done_kind", 32'(K_DONE), 32'(e.kind));
               chk("done_cpu_hold", 32'(cpu_hold), 32'(0));
               chk("done_error", 32'(error), 32'(0));
            end
         end
         if (error && !err_p) begin
            if (q.size() == 0) chk("unexpected_error", 32'(error), 32'(0));
            else begin
               e = q.pop_front();
               chk("err_kind", 32'(K_ERR), 32'(e.kind));
               chk("err_cpu_hold", 32'(cpu_hold), 32'(1));
               chk("err_done", 32'(done), 32'(0));
            end
         end
         done_p = done;
         err_p  = error;
      end
   end

   // Present one byte after 'gap' idle cycles; returns 1 time unit after the accepting edge.
   task automatic send(input logic [7:0] b, input int gap);
      logic rdy;
      int guard;
      bus.rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      guard = 0;
      forever begin
         rdy = bus.rx_ready;
         @(posedge clk);
         if (rdy) break;
         #1;
         guard++;
         if (guard > 10) begin
            n_fail++;
            $display("FAIL rx_ready_stuck: byte 0x%0h not accepted, expected acceptance", b);
            $fatal(1, "rx_ready never asserted");
         end
      end
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic push(input int kind, input logic [4:0] a, input logic [15:0] d);
      exp_t x;
      x.kind = kind;
      x.addr = a;
      x.data = d;
      q.push_back(x);
   endtask

   task automatic send_instr(input logic [4:0] a, input logic [15:0] d, input int gap);
      push(K_WR, a, d);
      send(d[15:8], gap);
      send(d[7:0], gap);
   endtask

   initial begin
      logic [15:0] img[32];
      logic [7:0]  cs;
      int          waited;

      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'(1));
      chk("rst_pm_we", 32'(bus.pm_we), 32'(0));
      chk("rst_pm_addr", 32'(bus.pm_addr), 32'(0));
      chk("rst_pm_wdata", 32'(bus.pm_wdata), 32'(0));
      chk("rst_cpu_hold", 32'(cpu_hold), 32'(1));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_error", 32'(error), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Leading junk ignored, then a one-instruction frame
      send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
      chk("junk_cpu_hold", 32'(cpu_hold), 32'(1));
      send(8'hA5, 0); send(8'h01, 0);
      send_instr(5'd0, 16'h0007, 0);
      push(K_DONE, 5'd0, 16'h0);
      send(8'h07, 0);
      chk("one_done", 32'(done), 32'(1));
      chk("one_cpu_hold", 32'(cpu_hold), 32'(0));

      // Two-instruction good frame
      send(8'hA5, 0);
      chk("restart_done_clr", 32'(done), 32'(0));
      chk("restart_hold", 32'(cpu_hold), 32'(1));
      send(8'h02, 0);
      send_instr(5'd0, 16'h1234, 0);
      send_instr(5'd1, 16'hABCD, 1);
      push(K_DONE, 5'd0, 16'h0);
      send(8'hBE, 0);
      chk("a_done", 32'(done), 32'(1));
      chk("a_cpu_hold", 32'(cpu_hold), 32'(0));
      chk("a_error", 32'(error), 32'(0));

      // Same frame, bad checksum
      send(8'hA5, 0); send(8'h02, 0);
      send_instr(5'd0, 16'h1234, 0);
      send_instr(5'd1, 16'hABCD, 0);
      push(K_ERR, 5'd0, 16'h0);
      send(8'hBF, 0);
      chk("b_error", 32'(error), 32'(1));
      chk("b_cpu_hold", 32'(cpu_hold), 32'(1));
      chk("b_done", 32'(done), 32'(0));

      // Illegal lengths 0 and 33
      send(8'hA5, 0);
      chk("len0_err_clr", 32'(error), 32'(0));
      push(K_ERR, 5'd0, 16'h0);
      send(8'h00, 0);
      chk("len0_error", 32'(error), 32'(1));
      send(8'hA5, 0);
      push(K_ERR, 5'd0, 16'h0);
      send(8'h21, 0);
      chk("len33_error", 32'(error), 32'(1));

      // Timeout mid-frame, then restart
      send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0);
      repeat (TMO - 2) @(posedge clk);
      #1;
      chk("tmo_early", 32'(error), 32'(0));
      push(K_ERR, 5'd0, 16'h0);
      waited = 0;
      while (!error && waited < 8) begin
         @(posedge clk);
         #1;
         waited++;
      end
      chk("tmo_error", 32'(error), 32'(1));
      send(8'hA5, 0);
      chk("tmo_restart_clr", 32'(error), 32'(0));

      // Build the 32-instruction image; first word contains start bytes as data
      cs = 8'h00;
      for (int i = 0; i < 32; i++) begin
         img[i] = (i == 0) ? 16'hA5A5 : 16'((i * 16'h0731) ^ 16'hA5C3);
         cs = cs + img[i][15:8] + img[i][7:0];
      end

      // Abort a 32-instruction load by reset after HI of instruction 5
      send(8'h20, 0);
      for (int i = 0; i < 4; i++) send_instr(5'(i), img[i], 0);
      send(img[4][15:8], 0);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_rx_ready", 32'(bus.rx_ready), 32'(1));
      chk("mid_rst_pm_we", 32'(bus.pm_we), 32'(0));
      chk("mid_rst_pm_addr", 32'(bus.pm_addr), 32'(0));
      chk("mid_rst_pm_wdata", 32'(bus.pm_wdata), 32'(0));
      chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'(1));
      chk("mid_rst_done", 32'(done), 32'(0));
      chk("mid_rst_error", 32'(error), 32'(0));
      chk("mid_rst_writes_seen", 32'(q.size()), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Full load with random gaps
      send(8'hA5, $urandom_range(0, 3));
      send(8'h20, $urandom_range(0, 3));
      for (int i = 0; i < 32; i++) send_instr(5'(i), img[i], $urandom_range(0, 3));
      push(K_DONE, 5'd0, 16'h0);
      send(cs, $urandom_range(0, 3));
      chk("full_done", 32'(done), 32'(1));
      chk("full_cpu_hold", 32'(cpu_hold), 32'(0));

      // Second start byte reasserts hold
      send(8'hA5, 2);
      chk("rehold_cpu_hold", 32'(cpu_hold), 32'(1));
      chk("rehold_done", 32'(done), 32'(0));

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that fills the core's writable program memory before execution. It sits between a host byte source (a UART receiver or test harness) and the program memory write port. It holds the core in reset while loading, frames and checksums the incoming image, and releases the core only after a verified load.

## Interface
Parameters:
- ADDR_W, 5, program memory address width (32 instructions)
- INSTR_W, 16, instruction width; fixed at two bytes, high byte first
- TIMEOUT, 1000, idle cycles allowed between bytes inside a frame before abort

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous, active-low
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte
- pm_we  output  1  program memory write strobe, one-cycle pulse
- pm_addr  output  ADDR_W  write address
- pm_wdata  output  INSTR_W  write data
- cpu_hold  output  1  holds the core's PC and accumulator in reset while high
- done  output  1  last load verified
- error  output  1  last load failed (bad length, checksum or timeout)

## Operation
- Frame: START (0xA5), LEN (N, instruction count), then N × {HI, LO}, then CSUM.
- CSUM is the 8-bit sum, modulo 256, of all 2N instruction bytes. START and LEN are excluded.
- Valid N is 1..32. N = 0 or N > 32 goes to ERR immediately.
- A byte is accepted on a rising edge with rx_valid && rx_ready.
- FSM states and transitions:
  - IDLE: discard every byte except 0xA5; 0xA5 → LEN.
  - LEN: N legal → latch N, clear index and sum → HI; N illegal → ERR.
  - HI: latch the high byte, add it to sum → LO.
  - LO: latch the low byte, add it to sum → WRITE.
  - WRITE: no byte accepted (rx_ready = 0); pm_we = 1, pm_addr = index, pm_wdata = {HI, LO}. If index == N−1 → CSUM; otherwise index++ and → HI.
  - CSUM: byte == sum → DONE; otherwise → ERR.
  - DONE: done = 1, cpu_hold = 0.
  - ERR: error = 1, cpu_hold = 1.
- In DONE and ERR, an accepted 0xA5 restarts the load → LEN. On the next cycle done and error clear and cpu_hold = 1.
- In DONE and ERR, all other bytes are discarded.
- 0xA5 inside a frame is ordinary data, not a restart.
- Timeout:
  - A counter clears on every accepted byte and increments in LEN, HI, LO and CSUM.
  - When it reaches TIMEOUT → ERR.
  - The counter does not run in IDLE, WRITE, DONE or ERR.
- Width rules:
  - N is held in 6 bits; index is ADDR_W bits and never wraps, since it is bounded by N−1 ≤ 31.
  - sum is 8 bits and wraps.
- Instructions already written before an error stay in memory. The core is not released.

## Timing
- Reset values: state IDLE, rx_ready 1, pm_we 0, pm_addr 0, pm_wdata 0, cpu_hold 1, done 0, error 0. Index, sum, N and the timeout counter all reset to 0.
- Reset asserted mid-frame returns the block to these values immediately (asynchronous). The partial image is abandoned.
- All outputs are registered, except rx_ready, which is decoded from state (0 only in WRITE).
- The pm_we pulse occurs exactly one cycle after the LO byte is accepted. pm_addr and pm_wdata are stable during that cycle.
- cpu_hold falls and done rises in the same cycle: one cycle after a matching CSUM byte is accepted.
- error rises one cycle after the failing LEN or CSUM byte is accepted, or when the timeout counter reaches TIMEOUT.
- Minimum frame duration is 2 + 3N + 1 cycles with rx_valid held high.
- rx_valid may deassert between any two bytes; the stall only advances the timeout counter.

## Structure
- Package loader_pkg holds:
  - the state enum (IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR)
  - START_BYTE = 8'hA5
  - MAX_INSTR = 32
- One sub-module, loader_timeout: a clear/enable counter with a terminal flag at TIMEOUT.
- Everything else (FSM, index, sum, data latches) lives in program_loader.

## Test plan
- Stream A5 02 12 34 AB CD BE → pm_we at addr 0 with 0x1234, then at addr 1 with 0xABCD; done = 1, cpu_hold = 0, error = 0.
- Same stream with CSUM 0xBF → both writes occur, error = 1, cpu_hold = 1, done = 0.
- Streams A5 00 and A5 21 → error one cycle after LEN; no pm_we ever.
- Bytes 00 FF 5A sent before A5 01 00 07 07 → leading bytes ignored; one write, addr 0 data 0x0007; done = 1.
- Stream A5 02 12, then rx_valid low for TIMEOUT cycles → error = 1.
  - A 0xA5 sent afterwards restarts the load; error clears the next cycle.
- Assert rst low after the HI byte of instruction 5 of a 32-instruction load → all outputs take their reset values immediately.
  - Then send a full 32-instruction load with random rx_valid gaps → writes to addresses 0..31 in order, done = 1.
  - A second 0xA5 then reasserts cpu_hold and clears done.
